// File: rtl/tv_player_checker.sv
// rtl/tv_player_checker.sv - on-chip test-vector player and masked response checker
//
// Holds DEPTH vectors {stim, exp, mask}. Each vector is applied to the DUT for
// LAT cycles. At the end of those cycles the DUT response is compared against
// exp under mask. The block counts mismatches with a saturating counter and
// captures the index of the first failing vector.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   ld_en/ld_addr/ld_stim/
//   ld_exp/ld_mask            host write port for one vector entry (IDLE/DONE only)
//   num_vec, stop_fail        run length and stop-on-first-fail, sampled on start
//   start, abort              begin run / cancel run (abort wins over start)
//   stim_out                  registered stimulus to the DUT
//   dut_out                   DUT response
//   busy, done, pass          run status; pass is meaningful only with done
//   err_cnt                   saturating mismatch count for this run
//   fail_valid, fail_idx      first-failure capture
//   vec_idx                   index of the vector currently applied
module tv_player_checker #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int LAT    = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [IN_W-1:0]   ld_stim,
  input  logic [OUT_W-1:0]  ld_exp,
  input  logic [OUT_W-1:0]  ld_mask,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              stop_fail,
  input  logic              start,
  input  logic              abort,
  output logic [IN_W-1:0]   stim_out,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [ADDR_W-1:0] vec_idx
);

  localparam int WC_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [IN_W-1:0]  stim_mem [DEPTH];
  logic [OUT_W-1:0] exp_mem  [DEPTH];
  logic [OUT_W-1:0] mask_mem [DEPTH];

  logic [ADDR_W:0]   n_lat;
  logic              stop_lat;
  logic [WC_W-1:0]   wait_cnt;

  logic              ld_ok;
  logic              start_go;
  logic              cmp_edge;
  logic              mism;
  logic              last_vec;
  logic              end_run;
  logic [ADDR_W:0]   n_eff;
  logic [IN_W-1:0]   first_stim;
  logic [ADDR_W-1:0] next_idx;

  always_comb begin
    ld_ok      = ld_en && (state != RUN) && ({1'b0, ld_addr} < (ADDR_W+1)'(DEPTH));
    start_go   = start && !abort && (state != RUN);
    n_eff      = (num_vec > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_vec;
    // A write to entry 0 on the start cycle lands in memory on the same edge,
    // so forward it so the run sees the new entry.
    first_stim = (ld_ok && (ld_addr == '0)) ? ld_stim : stim_mem[0];
    // wait_cnt counts 0..LAT-1; the last count marks the compare edge.
    cmp_edge   = (state == RUN) && (wait_cnt == WC_W'(LAT - 1));
    mism       = |((dut_out ^ exp_mem[vec_idx]) & mask_mem[vec_idx]);
    last_vec   = ({1'b0, vec_idx} == (n_lat - 1'b1));
    end_run    = cmp_edge && (last_vec || (mism && stop_lat));
    next_idx   = vec_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_go) state_nxt = (n_eff == '0) ? DONE : RUN;
      RUN: begin
        if (abort)        state_nxt = IDLE;
        else if (end_run) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vector memory is deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      stim_mem[ld_addr] <= ld_stim;
      exp_mem[ld_addr]  <= ld_exp;
      mask_mem[ld_addr] <= ld_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim_out   <= '0;
      vec_idx    <= '0;
      wait_cnt   <= '0;
      n_lat      <= '0;
      stop_lat   <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else if (state == RUN) begin
      if (!abort) begin
        if (cmp_edge) begin
          if (mism) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= vec_idx;
            end
          end
          if (!end_run) begin
            vec_idx  <= next_idx;
            stim_out <= stim_mem[next_idx];
          end
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end else if (start_go) begin
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      n_lat      <= n_eff;
      stop_lat   <= stop_fail;
      wait_cnt   <= '0;
      if (n_eff != '0) begin
        stim_out <= first_stim;
        vec_idx  <= '0;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_cnt == '0);

endmodule

// File: tb/tb_tv_player_checker.sv
// tb/tb_tv_player_checker.sv - self-checking bench for tv_player_checker (LAT=1 and LAT=3 instances)
module tb_tv_player_checker;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       ld_en;
  logic [3:0] ld_addr;
  logic [7:0] ld_stim, ld_exp, ld_mask;
  logic [4:0] num_vec;
  logic       stop_fail, start_a, start_b, abort;

  logic [7:0]  stim_a, stim_b, dut_a, dut_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;
  logic [15:0] err_a;
  logic [2:0]  err_b;
  logic [3:0]  fidx_a, fidx_b, vidx_a, vidx_b;

  int         flip_at = -1;
  logic [7:0] flip_val = 8'h00;

  // DUT model: response is stimulus + 1, optionally corrupted on one vector.
  always_comb begin
    dut_a = (stim_a + 8'd1) ^ ((int'(vidx_a) == flip_at) ? flip_val : 8'h00);
    dut_b = (stim_b + 8'd1) ^ ((int'(vidx_b) == flip_at) ? flip_val : 8'h00);
  end

  tv_player_checker #(.IN_W(8), .OUT_W(8), .DEPTH(16), .ADDR_W(4), .LAT(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_stim(ld_stim),
    .ld_exp(ld_exp), .ld_mask(ld_mask), .num_vec(num_vec), .stop_fail(stop_fail),
    .start(start_a), .abort(abort), .stim_out(stim_a), .dut_out(dut_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_valid(fv_a), .fail_idx(fidx_a),
    .vec_idx(vidx_a));

  tv_player_checker #(.IN_W(8), .OUT_W(8), .DEPTH(16), .ADDR_W(4), .LAT(3), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_stim(ld_stim),
    .ld_exp(ld_exp), .ld_mask(ld_mask), .num_vec(num_vec), .stop_fail(stop_fail),
    .start(start_b), .abort(abort), .stim_out(stim_b), .dut_out(dut_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_valid(fv_b), .fail_idx(fidx_b),
    .vec_idx(vidx_b));

  logic        sel;
  logic        o_busy, o_done, o_pass, o_fv;
  logic [15:0] o_err;
  logic [3:0]  o_fidx, o_vidx;
  logic [7:0]  o_stim;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_pass = sel ? pass_b : pass_a;
  assign o_fv   = sel ? fv_b   : fv_a;
  assign o_err  = sel ? {13'd0, err_b} : err_a;
  assign o_fidx = sel ? fidx_b : fidx_a;
  assign o_vidx = sel ? vidx_b : vidx_a;
  assign o_stim = sel ? stim_b : stim_a;

  logic [7:0] m_stim [DEPTH];
  logic [7:0] m_exp  [DEPTH];
  logic [7:0] m_mask [DEPTH];

  int tests = 0;
  int fails = 0;

  task automatic load(input int a, input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a[3:0]; ld_stim = s; ld_exp = e; ld_mask = m;
    m_stim[a] = s; m_exp[a] = e; m_mask[a] = m;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Reference: walk the vectors in order, apply the stated compare rule.
  task automatic model_run(input int n, input bit stop, input int lat, input int sat,
                           output int cyc, output int err, output bit fv,
                           output int fidx, output int last);
    int ne;
    logic [7:0] resp;
    ne = (n > DEPTH) ? DEPTH : n;
    err = 0; fv = 1'b0; fidx = 0; last = -1;
    for (int k = 0; k < ne; k++) begin
      resp = (m_stim[k] + 8'd1) ^ ((k == flip_at) ? flip_val : 8'h00);
      last = k;
      if (((resp ^ m_exp[k]) & m_mask[k]) != 8'h00) begin
        if (err < sat) err++;
        if (!fv) begin fv = 1'b1; fidx = k; end
        if (stop) break;
      end
    end
    cyc = (last + 1) * lat;
  endtask

  task automatic run_check(input string name, input bit s, input int n, input bit stop, input bit ld0);
    int lat, sat, ecyc, eerr, efidx, elast, c;
    bit efv, bad;
    logic [7:0] prev, estim;
    lat = s ? 3 : 1;
    sat = s ? 7 : 65535;
    model_run(n, stop, lat, sat, ecyc, eerr, efv, efidx, elast);
    sel = s;
    @(negedge clk);
    prev = o_stim;
    num_vec = n[4:0]; stop_fail = stop;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    if (ld0) begin
      ld_en = 1'b1; ld_addr = 4'd0; ld_stim = m_stim[0]; ld_exp = m_exp[0]; ld_mask = m_mask[0];
    end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; ld_en = 1'b0;
    c = 0; bad = 1'b0;
    while (!o_done && c < 400) begin
      if (!o_busy || (o_stim !== m_stim[c / lat])) bad = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    estim = (elast >= 0) ? m_stim[elast] : prev;
    tests++; if (c != ecyc) begin fails++; $display("FAIL %s cycles: got %0d want %0d", name, c, ecyc); end
    tests++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin fails++; $display("FAIL %s done/busy: got %b/%b want 1/0", name, o_done, o_busy); end
    tests++; if (bad) begin fails++; $display("FAIL %s stim_trace: got mismatch want stim[c/LAT] each cycle", name); end
    tests++; if (o_err !== 16'(eerr)) begin fails++; $display("FAIL %s err_cnt: got %0d want %0d", name, o_err, eerr); end
    tests++; if (o_fv !== efv || o_fidx !== 4'(efidx)) begin fails++; $display("FAIL %s fail_valid/idx: got %b/%0d want %b/%0d", name, o_fv, o_fidx, efv, efidx); end
    tests++; if (o_pass !== (eerr == 0)) begin fails++; $display("FAIL %s pass: got %b want %b", name, o_pass, (eerr == 0)); end
    tests++; if (o_stim !== estim) begin fails++; $display("FAIL %s stim_out: got %h want %h", name, o_stim, estim); end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (o_stim !== 8'h00 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
        o_err !== 16'h0 || o_fv !== 1'b0 || o_fidx !== 4'h0 || o_vidx !== 4'h0) begin
      fails++;
      $display("FAIL %s: got stim=%h busy=%b done=%b pass=%b err=%0d fv=%b fidx=%0d vidx=%0d want all 0",
               name, o_stim, o_busy, o_done, o_pass, o_err, o_fv, o_fidx, o_vidx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_stim = '0; ld_exp = '0; ld_mask = '0;
    num_vec = '0; stop_fail = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    sel = 1'b0; #1 check_zero("reset_a");
    sel = 1'b1; #1 check_zero("reset_b");
  endtask

  task automatic test_spec_vectors();
    flip_at = -1;
    for (int i = 0; i < 4; i++) load(i, 8'(i + 1), 8'(i + 2), 8'hFF);
    run_check("basic", 1'b0, 4, 1'b0, 1'b0);
    load(2, 8'd3, 8'h00, 8'hFF);
    run_check("fail_mid", 1'b0, 4, 1'b0, 1'b0);
    load(1, 8'd2, 8'h00, 8'hFF);
    load(2, 8'd3, 8'd4, 8'hFF);
    load(3, 8'd4, 8'h00, 8'hFF);
    run_check("stop_fail", 1'b0, 4, 1'b1, 1'b0);
    load(1, 8'd2, 8'd3, 8'hFF);
    load(3, 8'd4, 8'd5, 8'hFF);
    load(2, 8'd3, 8'd4, 8'h0F);
    flip_at = 2; flip_val = 8'h80;
    run_check("mask", 1'b0, 4, 1'b0, 1'b0);
    flip_at = -1;
    run_check("zero_a", 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_lat3();
    logic [7:0] s;
    for (int i = 0; i < DEPTH; i++) begin
      s = 8'($urandom);
      load(i, s, s + 8'd1, 8'hFF);
    end
    run_check("lat3_n16", 1'b1, 16, 1'b0, 1'b0);
    run_check("zero_b", 1'b1, 0, 1'b0, 1'b0);
    run_check("oversize_a", 1'b0, 20, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) load(i, m_stim[i], ~(m_stim[i] + 8'd1), 8'hFF);
    run_check("saturate_b", 1'b1, 16, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] s, e, m;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        s = 8'($urandom);
        e = ($urandom_range(0, 3) == 0) ? 8'($urandom) : s + 8'd1;
        case ($urandom_range(0, 3))
          0: m = 8'h00;
          1: m = 8'($urandom);
          default: m = 8'hFF;
        endcase
        load(i, s, e, m);
      end
      flip_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
      flip_val = 8'($urandom_range(1, 255));
      run_check($sformatf("random_%0d", it), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'b0);
    end
    flip_at = -1;
  endtask

  task automatic test_abort_and_ld_busy();
    for (int i = 0; i < DEPTH; i++) load(i, 8'(i * 7 + 1), 8'(i * 7 + 2), 8'hFF);
    sel = 1'b0;
    @(negedge clk); num_vec = 5'd8; stop_fail = 1'b0; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk); ld_en = 1'b1; ld_addr = 4'd0; ld_stim = 8'hAA; ld_exp = 8'h55; ld_mask = 8'hFF;
    @(posedge clk); #1 ld_en = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    tests++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin fails++; $display("FAIL abort: got busy=%b done=%b want 0/0", o_busy, o_done); end
    tests++; if (o_err !== 16'h0 || o_fv !== 1'b0) begin fails++; $display("FAIL abort_partial: got err=%0d fv=%b want 0/0", o_err, o_fv); end
    @(negedge clk); start_a = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; abort = 1'b0;
    tests++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin fails++; $display("FAIL abort_wins: got busy=%b done=%b want 0/0", o_busy, o_done); end
    run_check("ld_during_run_ignored", 1'b0, 4, 1'b0, 1'b0);
  endtask

  task automatic test_start_with_load();
    m_stim[0] = 8'h5A; m_exp[0] = 8'h5B; m_mask[0] = 8'hFF;
    run_check("start_ld_same", 1'b1, 3, 1'b0, 1'b1);
  endtask

  task automatic test_rst_mid_run();
    sel = 1'b1;
    @(negedge clk); num_vec = 5'd16; stop_fail = 1'b0; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1 check_zero("rst_mid_run");
    @(negedge clk); rst = 1'b0;
    run_check("post_rst_memory", 1'b1, 16, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_lat3();
    test_random();
    test_abort_and_ld_busy();
    test_start_with_load();
    test_rst_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
